// File: rtl/mmio_port_bank_pkg.sv
// Shared decode constants, register-select enum and byte-lane helper for mmio_port_bank.
package mmio_port_bank_pkg;

   localparam logic [7:0] MMIO_CHANGE_FLAGS_OFFSET = 8'h80;
   localparam logic [7:0] MMIO_INT_ENABLE_OFFSET   = 8'h84;

   typedef enum logic [1:0] {
      MMIO_PORT,
      MMIO_FLAGS,
      MMIO_INTEN,
      MMIO_NONE
   } MmioRegSelect_t;

   // Expand a 4-bit byte enable into a 32-bit bit mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      logic [31:0] mask;
      mask = '0;
      for (int n = 0; n < 4; n++) begin
         mask[8*n +: 8] = {8{be[n]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/mmio_input_synchronizer.sv
// Multi-stage synchroniser for one 32-bit asynchronous input channel.
module mmio_input_synchronizer #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic [31:0] async_i,
   output logic [31:0] sync_o
);

   logic [SYNC_STAGES-1:0][31:0] chain_q;

   // Shift the raw input through the chain; the last stage is the safe value.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
      end
   end

   assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of synchronised input / registered output words with
// sticky change flags and a masked, registered interrupt.
module mmio_port_bank
   import mmio_port_bank_pkg::*;
#(
   parameter int unsigned NUM_PORTS          = 8,
   parameter logic [31:0] BASE_ADDRESS       = 32'hFFFFFF00,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter logic [31:0] OUTPUT_RESET_VALUE = 32'h00000000
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic [31:0]                 address_i,
   input  logic [31:0]                 write_data_i,
   input  logic [3:0]                  byte_enable_i,
   input  logic                        write_enable_i,
   input  logic                        read_enable_i,
   output logic                        hit_o,
   output logic                        bad_access_o,
   output logic [31:0]                 read_data_o,
   input  logic [NUM_PORTS-1:0][31:0]  mmio_inputs_i,
   output logic [NUM_PORTS-1:0][31:0]  mmio_outputs_o,
   output logic                        interrupt_o
);

   localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

   logic [NUM_PORTS-1:0][31:0] sync_in;
   logic [NUM_PORTS-1:0][31:0] prev_q;
   logic [NUM_PORTS-1:0][31:0] out_q, out_d;
   logic [NUM_PORTS-1:0]       flags_q, flags_d;
   logic [NUM_PORTS-1:0]       inten_q, inten_d;
   logic [NUM_PORTS-1:0]       change;
   logic [2:0]                 warm_q, warm_d;
   logic                       irq_q, irq_d;
   logic                       warm_done;

   logic           in_window, aligned, wr_en;
   logic [7:0]     offset;
   logic [4:0]     port_idx;
   logic [31:0]    wr_mask, wr_bits;
   MmioRegSelect_t sel;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sync
      mmio_input_synchronizer #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clock_i (clock_i),
         .reset_i (reset_i),
         .async_i (mmio_inputs_i[i]),
         .sync_o  (sync_in[i])
      );
   end

   assign in_window    = (address_i[31:8] == BASE_ADDRESS[31:8]);
   assign aligned      = (address_i[1:0] == 2'b00);
   assign offset       = address_i[7:0];
   assign port_idx     = offset[6:2];
   assign bad_access_o = in_window && !aligned;
   assign hit_o        = in_window && aligned && (sel != MMIO_NONE);
   assign wr_en        = write_enable_i && hit_o;
   assign wr_mask      = byte_mask(byte_enable_i);
   assign wr_bits      = write_data_i & wr_mask;
   assign warm_done    = (warm_q == WARM_DONE);

   // Decode the window offset into a register select.
   always_comb begin
      sel = MMIO_NONE;
      if (offset == MMIO_CHANGE_FLAGS_OFFSET) begin
         sel = MMIO_FLAGS;
      end else if (offset == MMIO_INT_ENABLE_OFFSET) begin
         sel = MMIO_INTEN;
      end else if (!offset[7] && (32'(port_idx) < NUM_PORTS)) begin
         sel = MMIO_PORT;
      end
   end

   // Combinational read mux; sourced only from registered state.
   always_comb begin
      read_data_o = '0;
      if (read_enable_i && hit_o) begin
         unique case (sel)
            MMIO_PORT: begin
               for (int i = 0; i < NUM_PORTS; i++) begin
                  if (port_idx == 5'(i)) read_data_o = sync_in[i];
               end
            end
            MMIO_FLAGS: read_data_o = 32'(flags_q);
            MMIO_INTEN: read_data_o = 32'(inten_q);
            MMIO_NONE:  read_data_o = '0;
         endcase
      end
   end

   // Next-state: byte-lane writes, W1C flags (set wins), warm-up and interrupt.
   always_comb begin
      out_d   = out_q;
      inten_d = inten_q;
      flags_d = flags_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         change[i] = warm_done && (sync_in[i] != prev_q[i]);
         if (wr_en && (sel == MMIO_PORT) && (port_idx == 5'(i))) begin
            out_d[i] = (out_q[i] & ~wr_mask) | wr_bits;
         end
      end
      if (wr_en && (sel == MMIO_INTEN)) begin
         inten_d = (inten_q & ~wr_mask[NUM_PORTS-1:0]) | wr_bits[NUM_PORTS-1:0];
      end
      if (wr_en && (sel == MMIO_FLAGS)) begin
         flags_d = flags_q & ~wr_bits[NUM_PORTS-1:0];
      end
      flags_d = flags_d | change;
      warm_d  = warm_done ? warm_q : warm_q + 3'd1;
      irq_d   = |(flags_q & inten_q);
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         out_q   <= {NUM_PORTS{OUTPUT_RESET_VALUE}};
         prev_q  <= '0;
         flags_q <= '0;
         inten_q <= '0;
         warm_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         prev_q  <= sync_in;
         flags_q <= flags_d;
         inten_q <= inten_d;
         warm_q  <= warm_d;
         irq_q   <= irq_d;
      end
   end

   assign mmio_outputs_o = out_q;
   assign interrupt_o    = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed self-checking bench for mmio_port_bank (4 ports, 2 sync stages).
module tb_mmio_port_bank;

   localparam int unsigned NP = 4;
   localparam logic [31:0] RV = 32'h5A5A0000;
   localparam logic [31:0] B  = 32'hFFFFFF00;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [31:0]          address, write_data, read_data;
   logic [3:0]           byte_enable;
   logic                 write_enable, read_enable;
   logic                 hit, bad_access, interrupt;
   logic [NP-1:0][31:0]  mmio_in, mmio_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mmio_port_bank #(
      .NUM_PORTS          (NP),
      .BASE_ADDRESS       (B),
      .SYNC_STAGES        (2),
      .OUTPUT_RESET_VALUE (RV)
   ) dut (
      .clock_i        (clk),
      .reset_i        (rst),
      .address_i      (address),
      .write_data_i   (write_data),
      .byte_enable_i  (byte_enable),
      .write_enable_i (write_enable),
      .read_enable_i  (read_enable),
      .hit_o          (hit),
      .bad_access_o   (bad_access),
      .read_data_o    (read_data),
      .mmio_inputs_i  (mmio_in),
      .mmio_outputs_o (mmio_out),
      .interrupt_o    (interrupt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      address      = a;
      write_data   = d;
      byte_enable  = be;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      byte_enable  = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      address     = a;
      read_enable = 1'b1;
      #1;
      d           = read_data;
      read_enable = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      mmio_in = '0;
      mmio_in[3] = 32'hDEADBEEF;
      tick();
      tick();
      checks++;
      if (mmio_out !== {NP{RV}}) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", mmio_out, {NP{RV}});
      end
      checks++;
      if (interrupt !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b expected 0", interrupt);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rd(B + 32'h0C, d);
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL reset_read_in3: got %h expected deadbeef", d);
      end
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL reset_flags: got %h expected 0", d);
      end
      checks++;
      if (interrupt !== 1'b0) begin
         errors++;
         $display("FAIL reset_live_irq: got %b expected 0", interrupt);
      end
   endtask

   task automatic test_byte_write();
      wr(B + 32'h04, 32'hAAAAAAAA, 4'hF);
      checks++;
      if (mmio_out[1] !== 32'hAAAAAAAA) begin
         errors++;
         $display("FAIL full_write: got %h expected aaaaaaaa", mmio_out[1]);
      end
      wr(B + 32'h04, 32'h11223344, 4'b0101);
      checks++;
      if (mmio_out[1] !== 32'hAA22AA44) begin
         errors++;
         $display("FAIL byte_write: got %h expected aa22aa44", mmio_out[1]);
      end
      wr(B + 32'h04, 32'h00000000, 4'b0000);
      checks++;
      if (mmio_out[1] !== 32'hAA22AA44) begin
         errors++;
         $display("FAIL be0_noop: got %h expected aa22aa44", mmio_out[1]);
      end
   endtask

   task automatic test_change_irq();
      logic [31:0] d;
      wr(B + 32'h84, 32'h00000004, 4'hF);
      rd(B + 32'h84, d);
      checks++;
      if (d !== 32'h4) begin
         errors++;
         $display("FAIL inten_read: got %h expected 4", d);
      end
      mmio_in[2] = 32'h00000001;
      tick();
      rd(B + 32'h08, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL sync_edge1: got %h expected 0", d);
      end
      tick();
      rd(B + 32'h08, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL sync_edge2: got %h expected 1", d);
      end
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL flag_edge2: got %h expected 0", d);
      end
      tick();
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h4) begin
         errors++;
         $display("FAIL flag_edge3: got %h expected 4", d);
      end
      checks++;
      if (interrupt !== 1'b0) begin
         errors++;
         $display("FAIL irq_edge3: got %b expected 0", interrupt);
      end
      tick();
      checks++;
      if (interrupt !== 1'b1) begin
         errors++;
         $display("FAIL irq_edge4: got %b expected 1", interrupt);
      end
      wr(B + 32'h80, 32'h00000004, 4'b0010);
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h4) begin
         errors++;
         $display("FAIL w1c_masked: got %h expected 4", d);
      end
      wr(B + 32'h80, 32'h00000004, 4'b0001);
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL w1c_clear: got %h expected 0", d);
      end
      checks++;
      if (interrupt !== 1'b1) begin
         errors++;
         $display("FAIL irq_hold: got %b expected 1", interrupt);
      end
      tick();
      checks++;
      if (interrupt !== 1'b0) begin
         errors++;
         $display("FAIL irq_fall: got %b expected 0", interrupt);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      mmio_in[0] = 32'h80000000;
      tick();
      tick();
      wr(B + 32'h80, 32'h00000001, 4'hF);
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL set_wins: got %h expected 1", d);
      end
      wr(B + 32'h80, 32'h00000001, 4'hF);
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL later_clear: got %h expected 0", d);
      end
   endtask

   task automatic test_decode();
      logic [31:0] d;
      logic [NP-1:0][31:0] exp_out;
      exp_out    = {RV, RV, 32'hAA22AA44, RV};
      rd(B + 32'h10, d);
      checks++;
      if (hit !== 1'b0 || d !== 32'h0) begin
         errors++;
         $display("FAIL unimpl_port: hit %b data %h expected 0 0", hit, d);
      end
      wr(B + 32'h10, 32'hFFFFFFFF, 4'hF);
      checks++;
      if (mmio_out !== exp_out) begin
         errors++;
         $display("FAIL unimpl_write: got %h expected %h", mmio_out, exp_out);
      end
      address = B + 32'h06;
      #1;
      checks++;
      if (bad_access !== 1'b1 || hit !== 1'b0) begin
         errors++;
         $display("FAIL misaligned: bad %b hit %b expected 1 0", bad_access, hit);
      end
      wr(B + 32'h06, 32'hFFFFFFFF, 4'hF);
      checks++;
      if (mmio_out[1] !== 32'hAA22AA44) begin
         errors++;
         $display("FAIL misaligned_write: got %h expected aa22aa44", mmio_out[1]);
      end
      address = 32'hFFFFFEFC;
      #1;
      checks++;
      if (hit !== 1'b0 || bad_access !== 1'b0) begin
         errors++;
         $display("FAIL below_window: hit %b bad %b expected 0 0", hit, bad_access);
      end
      address = B + 32'h88;
      #1;
      checks++;
      if (hit !== 1'b0) begin
         errors++;
         $display("FAIL hole_88: hit %b expected 0", hit);
      end
      address     = B + 32'h0C;
      read_enable = 1'b0;
      #1;
      checks++;
      if (hit !== 1'b1 || read_data !== 32'h0) begin
         errors++;
         $display("FAIL no_read_en: hit %b data %h expected 1 0", hit, read_data);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      wr(B + 32'h84, 32'h00000002, 4'hF);
      mmio_in[1] = 32'h000000FF;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (interrupt !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_irq: got %b expected 1", interrupt);
      end
      wr(B + 32'h08, 32'h12345678, 4'hF);
      checks++;
      if (mmio_out[2] !== 32'h12345678) begin
         errors++;
         $display("FAIL pre_reset_out: got %h expected 12345678", mmio_out[2]);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (mmio_out !== {NP{RV}} || interrupt !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: out %h irq %b expected %h 0", mmio_out, interrupt, {NP{RV}});
      end
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_flags: got %h expected 0", d);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rd(B + 32'h80, d);
      checks++;
      if (d !== 32'h0 || interrupt !== 1'b0) begin
         errors++;
         $display("FAIL rewarm: flags %h irq %b expected 0 0", d, interrupt);
      end
      rd(B + 32'h04, d);
      checks++;
      if (d !== 32'h000000FF) begin
         errors++;
         $display("FAIL rewarm_in1: got %h expected ff", d);
      end
   endtask

   initial begin
      address      = '0;
      write_data   = '0;
      byte_enable  = '0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      rst          = 1'b1;
      mmio_in      = '0;
      test_reset();
      test_byte_write();
      test_change_irq();
      test_collision();
      test_decode();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mmio_port_bank.md
# mmio_port_bank

Parametrised memory-mapped I/O bank that replaces the core's fixed 8-in/8-out word ports. It adds configurable channel count and base address, byte-granular writes, multi-stage input synchronisers, sticky per-channel change flags with interrupt masking, and misaligned-access detection. It sits beside the memory controller and claims every access whose address falls in its window.

## Interface
Parameters:
- NUM_PORTS, 8, number of 32-bit input/output channel pairs; legal range 1..32
- BASE_ADDRESS, 32'hFFFFFF00, byte address of channel 0; must be 256-byte aligned
- SYNC_STAGES, 2, flip-flop stages per input bit; legal range 2..4
- OUTPUT_RESET_VALUE, 32'h00000000, value loaded into every mmioOutputs word on reset

Ports:
- clock  in  1  single clock for all state
- reset  in  1  asynchronous, active-high
- address  in  32  byte address of the access
- writeData  in  32  store data
- byteEnable  in  4  byte lanes written; bit n selects writeData[8n+7:8n]
- writeEnable  in  1  store strobe, sampled at the rising clock edge
- readEnable  in  1  load strobe; qualifies hit for readData
- hit  out  1  address is inside the window, word-aligned, and decodes to an implemented register
- badAccess  out  1  address is inside the window but address[1:0] != 0
- readData  out  32  load result; combinational; '0 when not (readEnable && hit)
- mmioInputs  in  32 x NUM_PORTS  external inputs; may be asynchronous
- mmioOutputs  out  32 x NUM_PORTS  registered outputs
- interrupt  out  1  OR of (changeFlags & interruptEnable); registered

## Operation
- Register map (offsets from BASE_ADDRESS):
  - 0x00 + 4i (i < NUM_PORTS): a read returns the synchronised input i; a write updates output i.
  - 0x80 CHANGE_FLAGS: bit i is a sticky flag; write-1-to-clear; bits at and above NUM_PORTS read 0.
  - 0x84 INT_ENABLE: read/write; only bits [NUM_PORTS-1:0] are implemented.
  - All other offsets in the 256-byte window: hit=0. Writes are ignored; readData='0.
- Byte writes: for each lane n with byteEnable[n]=1, only that lane changes. byteEnable=0 with writeEnable=1 is a no-op. For CHANGE_FLAGS, the mask is applied before the W1C.
- Synchroniser: each input bit passes through a SYNC_STAGES-deep chain. The final stage is the value exposed to reads.
- Change detection:
  - A delayed copy of the final sync stage is kept for each channel.
  - If final stage != delayed copy, flag i is set.
- Warm-up: a counter runs from reset to SYNC_STAGES+1 cycles. Change detection is suppressed until it saturates, so the reset-to-live transition raises no flags.
- Simultaneous set and W1C of the same flag bit: set wins.
- A misaligned in-window access asserts badAccess, forces hit=0, and discards any write.

## Timing
- Reset values:
  - mmioOutputs = OUTPUT_RESET_VALUE
  - sync chains, delayed copies, CHANGE_FLAGS, INT_ENABLE, warm-up counter = 0
  - interrupt = 0
  - hit, badAccess and readData follow their combinational definitions
- Writes: take effect at the clock edge. Visible on mmioOutputs and readData in the following cycle.
- Reads: zero-latency combinational path from registered state only, with no combinational path from mmioInputs. The core's single-cycle load/store timing is preserved.
- Input latency:
  - An mmioInputs change is readable SYNC_STAGES edges later.
  - Its flag sets on the edge after that (SYNC_STAGES+1).
  - interrupt rises one edge later (SYNC_STAGES+2).
- W1C of the last enabled pending flag: interrupt falls on the edge after the flag clears.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. Warm-up restarts after deassertion.

## Structure
- JZJCoreFTypes gains:
  - offset localparams MMIO_CHANGE_FLAGS_OFFSET (8'h80) and MMIO_INT_ENABLE_OFFSET (8'h84)
  - an enum MmioRegSelect_t {MMIO_PORT, MMIO_FLAGS, MMIO_INTEN, MMIO_NONE} used by the decoder
- One sub-module, mmio_input_synchronizer: one parametrised 32-bit chain with SYNC_STAGES depth, instantiated NUM_PORTS times via generate.

## Test plan
- Reset: release reset with mmioInputs[3]=32'hDEADBEEF; after 10 cycles -> read 0xFFFFFF0C = DEADBEEF, CHANGE_FLAGS = 0, interrupt = 0.
- Byte write: write 0xFFFFFF04 with data 32'h11223344, byteEnable 4'b0101, and prior output 32'hAAAAAAAA -> mmioOutputs[1] = 32'hAA22AA44 on the next cycle.
- Change flag + interrupt: INT_ENABLE = 0x4, then toggle mmioInputs[2] -> flag bit 2 set at edge SYNC_STAGES+1, interrupt = 1 at edge SYNC_STAGES+2. W1C 0x4 -> interrupt = 0 one edge after the flag clears.
- Set vs. clear collision: W1C bit 0 on the same edge that the change on input 0 is detected -> bit 0 remains 1.
- Decode boundaries with NUM_PORTS=4:
  - 0xFFFFFF10 -> hit=0, readData=0, write ignored
  - 0xFFFFFF06 -> badAccess=1, output 1 unchanged
  - 0xFFFFFEFC -> hit=0, badAccess=0
- Reset mid-operation: assert reset asynchronously while flags are pending and outputs are written -> all outputs return to OUTPUT_RESET_VALUE before the next edge, and interrupt=0.
